regfile_param: RTL and testbench

Parametrised multi-entry register file for the microprocessor datapath, successor to the fixed 4x8 register bank. It provides two asynchronous read ports and one synchronous write port. Entry count and data width are configurable, and entry 0 can optionally be held at zero. A sequenced bulk-clear engine wipes all entries without a global reset, with a busy indication and dropped-write reporting.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_if.sv | 59 +++++
 rtl/regfile_clear_seq.sv | 107 ++++++++++
 rtl/regfile_param.sv | 132 +++++++++++++
 tb/tb_regfile_param.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the parametrised register file:
//               default geometry constants and the bulk-clear FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================

package regfile_pkg;

    // Default geometry, matching the legacy 4x8 register bank.
    localparam int REGFILE_DATA_W = 8;
    localparam int REGFILE_ADDR_W = 2;

    // Bulk-clear engine states. Explicit 1-bit encoding keeps the state
    // register width fixed regardless of tool enum defaults.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_if
// Description : Bus bundle between a datapath master and the register file:
//               two read addresses, one write port, bulk-clear request and
//               the read data / status returned by the register file.
// Revision    : 1.0 - initial release
// ============================================================================

interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
);

    // Request side (driven by the datapath)
    logic [ADDR_W-1:0] read_register_one;
    logic [ADDR_W-1:0] read_register_two;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic              RegWrite;
    logic              clear_req;

    // Response side (driven by the register file)
    logic [DATA_W-1:0] read_data_one;
    logic [DATA_W-1:0] read_data_two;
    logic              busy;
    logic              wr_drop;

    modport master (
        output read_register_one,
        output read_register_two,
        output write_register,
        output write_data,
        output RegWrite,
        output clear_req,
        input  read_data_one,
        input  read_data_two,
        input  busy,
        input  wr_drop
    );

    modport slave (
        input  read_register_one,
        input  read_register_two,
        input  write_register,
        input  write_data,
        input  RegWrite,
        input  clear_req,
        output read_data_one,
        output read_data_two,
        output busy,
        output wr_drop
    );

endinterface : regfile_if

`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_seq
// Description : Bulk-clear sequencer. Sweeps a pointer from 0 to DEPTH-1,
//               issuing one clear per cycle, flags busy for the duration and
//               reports writes that arrive while the sweep is running.
// Revision    : 1.0 - initial release
// ============================================================================

module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              reg_write,
    output logic              busy,
    output logic              wr_drop,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    // Last entry index; the pointer never counts past it.
    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_wr_drop;
    logic              w_last;

    assign w_last = (r_ptr == c_last_addr);

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: requests are only honoured from IDLE, so a request
    // during a sweep neither restarts nor queues another one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs: busy and the clear strobe follow the state directly.
    always_comb begin
        busy     = 1'b0;
        clr_en   = 1'b0;
        clr_addr = r_ptr;
        case (r_state)
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
            end
            default: begin
                busy   = 1'b0;
                clr_en = 1'b0;
            end
        endcase
    end

    // Sweep pointer: parked at 0 while idle, so every sweep starts at entry 0.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == CLEAR) begin
            r_ptr <= w_last ? '0 : (r_ptr + ADDR_W'(1));
        end else begin
            r_ptr <= '0;
        end
    end

    // Dropped-write flag: one-cycle pulse after a write lands during a sweep.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= reg_write && (r_state == CLEAR);
        end
    end

    assign wr_drop = r_wr_drop;

endmodule : regfile_clear_seq

`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param
// Description : Parametrised register file, DEPTH = 2**ADDR_W entries of
//               DATA_W bits. Two combinational read ports, one synchronous
//               write port, optional hard-wired zero entry and a sequenced
//               bulk-clear engine (regfile_clear_seq).
// Build macro : REGFILE_BYPASS_EN - when defined, a read of the address being
//               written in the same cycle returns the incoming write data.
// Revision    : 1.0 - initial release
// ============================================================================

module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic     CLK,
    input  logic     reset,
    regfile_if.slave bus
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];

    logic              w_busy;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_en;
    logic              w_wr_keep;
    logic              w_fwd_one;
    logic              w_fwd_two;
    logic [DATA_W-1:0] w_rd_one;
    logic [DATA_W-1:0] w_rd_two;

    // ------------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------------
    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .CLK       (CLK),
        .reset     (reset),
        .clear_req (bus.clear_req),
        .reg_write (bus.RegWrite),
        .busy      (w_busy),
        .wr_drop   (bus.wr_drop),
        .clr_en    (w_clr_en),
        .clr_addr  (w_clr_addr)
    );

    assign bus.busy = w_busy;

    // A write is accepted only while the clear engine is idle.
    assign w_wr_en = bus.RegWrite && !w_busy;

    // Writes to a hard-wired zero entry are silently discarded.
    assign w_wr_keep = w_wr_en &&
                       !((ZERO_REG != 0) && (bus.write_register == '0));

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // Entry array: async wipe on reset, then either one sweep clear or one
    // accepted write per cycle (the two never coincide, writes need !busy).
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_clr_en) begin
                r_mem[w_clr_addr] <= '0;
            end
            if (w_wr_keep) begin
                r_mem[bus.write_register] <= bus.write_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    // Write-through: only accepted writes are forwarded, never dropped ones.
    assign w_fwd_one = w_wr_en && (bus.read_register_one == bus.write_register);
    assign w_fwd_two = w_wr_en && (bus.read_register_two == bus.write_register);
`else
    // No forwarding: reads see the stored value until the write edge.
    assign w_fwd_one = 1'b0;
    assign w_fwd_two = 1'b0;
`endif

    // Selects stored or forwarded data, then applies the zero-entry rule
    // last so it overrides forwarding as well.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd,
        input logic [DATA_W-1:0] fwd_data
    );
        logic [DATA_W-1:0] v;
        v = fwd ? fwd_data : stored;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    // Read port one: combinational from address to data.
    always_comb begin
        w_rd_one = read_sel(bus.read_register_one,
                            r_mem[bus.read_register_one],
                            w_fwd_one, bus.write_data);
    end

    // Read port two: combinational from address to data.
    always_comb begin
        w_rd_two = read_sel(bus.read_register_two,
                            r_mem[bus.read_register_two],
                            w_fwd_two, bus.write_data);
    end

    assign bus.read_data_one = w_rd_one;
    assign bus.read_data_two = w_rd_two;

endmodule : regfile_param

`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_param
// Description : Scoreboard bench for regfile_param. Stimulus pushes expected
//               observations into a queue; a monitor on the falling edge pops
//               and compares them against the DUT outputs. Two instances:
//               default 8x4 (ZERO_REG=0) and 16x8 with ZERO_REG=1.
// Build macro : REGFILE_BYPASS_EN selects write-through expectations.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    localparam int K_A_RD1  = 0;
    localparam int K_A_RD2  = 1;
    localparam int K_A_BUSY = 2;
    localparam int K_A_DROP = 3;
    localparam int K_B_RD1  = 4;
    localparam int K_B_RD2  = 5;
    localparam int K_B_BUSY = 6;
    localparam int K_B_DROP = 7;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic CLK = 1'b0;
    logic reset;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    regfile_if #(.DATA_W(8),  .ADDR_W(2)) bus_a ();
    regfile_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

    regfile_param #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) dut_a (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut_b (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
        chk_t c;
        c.kind = kind;
        c.exp  = exp;
        c.name = name;
        sb_q.push_back(c);
    endtask

    function automatic logic [15:0] observe(input int kind);
        case (kind)
            K_A_RD1:  return {8'h00, bus_a.read_data_one};
            K_A_RD2:  return {8'h00, bus_a.read_data_two};
            K_A_BUSY: return {15'd0, bus_a.busy};
            K_A_DROP: return {15'd0, bus_a.wr_drop};
            K_B_RD1:  return bus_b.read_data_one;
            K_B_RD2:  return bus_b.read_data_two;
            K_B_BUSY: return {15'd0, bus_b.busy};
            K_B_DROP: return {15'd0, bus_b.wr_drop};
            default:  return 16'hxxxx;
        endcase
    endfunction

    // Monitor: drain every pending expectation at the falling edge.
    always @(negedge CLK) begin : monitor
        chk_t        c;
        logic [15:0] act;
        while (sb_q.size() > 0) begin
            c   = sb_q.pop_front();
            act = observe(c.kind);
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [7:0] fill [4];

    initial begin
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        reset = 1'b1;
        bus_a.read_register_one = '0; bus_a.read_register_two = '0;
        bus_a.write_register    = '0; bus_a.write_data        = '0;
        bus_a.RegWrite          = 1'b0; bus_a.clear_req       = 1'b0;
        bus_b.read_register_one = '0; bus_b.read_register_two = '0;
        bus_b.write_register    = '0; bus_b.write_data        = '0;
        bus_b.RegWrite          = 1'b0; bus_b.clear_req       = 1'b0;
        cyc(); cyc();

        // ---------------- reset state ----------------
        bus_a.read_register_one = 2'd2; bus_a.read_register_two = 2'd3;
        bus_b.read_register_one = 3'd7;
        expect_val(K_A_RD1,  16'h0, "rst_a_rd1");
        expect_val(K_A_RD2,  16'h0, "rst_a_rd2");
        expect_val(K_A_BUSY, 16'h0, "rst_a_busy");
        expect_val(K_A_DROP, 16'h0, "rst_a_drop");
        expect_val(K_B_RD1,  16'h0, "rst_b_rd1");
        expect_val(K_B_BUSY, 16'h0, "rst_b_busy");
        cyc();
        reset = 1'b0;
        cyc();

        // ---------------- write A5 to entry 2 ----------------
        bus_a.RegWrite = 1'b1; bus_a.write_register = 2'd2; bus_a.write_data = 8'hA5;
        bus_a.read_register_one = 2'd2; bus_a.read_register_two = 2'd3;
        expect_val(K_A_RD1, c_byp ? 16'h00A5 : 16'h0000, "wr_a5_same_cycle");
        cyc();
        bus_a.RegWrite = 1'b0;
        expect_val(K_A_RD1, 16'h00A5, "wr_a5_after_edge");
        expect_val(K_A_RD2, 16'h0000, "rd_e3_zero");
        cyc();

        // ---------------- read-during-write on entry 1 ----------------
        bus_a.RegWrite = 1'b1; bus_a.write_register = 2'd1; bus_a.write_data = 8'h3C;
        bus_a.read_register_one = 2'd1; bus_a.read_register_two = 2'd1;
        expect_val(K_A_RD1, c_byp ? 16'h003C : 16'h0000, "rdw_3c_port1");
        expect_val(K_A_RD2, c_byp ? 16'h003C : 16'h0000, "rdw_3c_port2");
        cyc();
        bus_a.RegWrite = 1'b0;
        expect_val(K_A_RD1, 16'h003C, "rdw_3c_after_edge");
        cyc();

        // ---------------- fill, then bulk clear ----------------
        for (int i = 0; i < 4; i++) begin
            bus_a.RegWrite = 1'b1; bus_a.write_register = 2'(i); bus_a.write_data = fill[i];
            cyc();
        end
        bus_a.RegWrite = 1'b0;
        bus_a.read_register_one = 2'd0; bus_a.read_register_two = 2'd1;
        expect_val(K_A_RD1, 16'h0011, "fill_e0");
        expect_val(K_A_RD2, 16'h0022, "fill_e1");
        cyc();
        bus_a.read_register_one = 2'd2; bus_a.read_register_two = 2'd3;
        expect_val(K_A_RD1, 16'h0033, "fill_e2");
        expect_val(K_A_RD2, 16'h0044, "fill_e3");
        cyc();
        bus_a.clear_req = 1'b1;
        expect_val(K_A_BUSY, 16'h0, "clr_req_idle");
        cyc();
        bus_a.clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus_a.read_register_one = 2'(k);
            bus_a.read_register_two = (k == 0) ? 2'd3 : 2'(k - 1);
            expect_val(K_A_BUSY, 16'h1, "clr_busy");
            expect_val(K_A_RD1, {8'h00, fill[k]}, "clr_pending_entry");
            expect_val(K_A_RD2, (k == 0) ? {8'h00, fill[3]} : 16'h0000, "clr_done_entry");
            cyc();
        end
        bus_a.read_register_one = 2'd3; bus_a.read_register_two = 2'd0;
        expect_val(K_A_BUSY, 16'h0, "clr_end_busy");
        expect_val(K_A_RD1, 16'h0, "clr_end_e3");
        expect_val(K_A_RD2, 16'h0, "clr_end_e0");
        cyc();

        // ---------------- write dropped during sweep ----------------
        bus_a.clear_req = 1'b1;
        cyc();
        bus_a.clear_req = 1'b0;
        expect_val(K_A_BUSY, 16'h1, "drop_busy1");
        cyc();
        bus_a.RegWrite = 1'b1; bus_a.write_register = 2'd3; bus_a.write_data = 8'h77;
        bus_a.read_register_one = 2'd3;
        bus_a.clear_req = 1'b1;
        expect_val(K_A_BUSY, 16'h1, "drop_busy2");
        expect_val(K_A_DROP, 16'h0, "drop_pre");
        expect_val(K_A_RD1,  16'h0, "drop_no_forward");
        cyc();
        bus_a.RegWrite = 1'b0; bus_a.clear_req = 1'b0;
        expect_val(K_A_DROP, 16'h1, "drop_pulse");
        expect_val(K_A_RD1,  16'h0, "drop_not_written");
        cyc();
        expect_val(K_A_DROP, 16'h0, "drop_one_cycle");
        expect_val(K_A_BUSY, 16'h1, "drop_busy4");
        cyc();
        expect_val(K_A_BUSY, 16'h0, "clr_req_ignored_when_busy");
        expect_val(K_A_RD1,  16'h0, "drop_e3_after");
        cyc();

        // ---------------- write and clear on the same idle edge ----------------
        bus_a.RegWrite = 1'b1; bus_a.write_register = 2'd2; bus_a.write_data = 8'h9A;
        bus_a.clear_req = 1'b1; bus_a.read_register_one = 2'd2;
        expect_val(K_A_BUSY, 16'h0, "wc_idle");
        cyc();
        bus_a.RegWrite = 1'b0; bus_a.clear_req = 1'b0;
        expect_val(K_A_BUSY, 16'h1, "wc_busy");
        expect_val(K_A_RD1, 16'h009A, "wc_committed");
        expect_val(K_A_DROP, 16'h0, "wc_no_drop");
        cyc(); cyc();
        expect_val(K_A_RD1, 16'h009A, "wc_pending");
        cyc();
        expect_val(K_A_RD1, 16'h0, "wc_cleared");
        expect_val(K_A_BUSY, 16'h1, "wc_busy_last");
        cyc();
        expect_val(K_A_BUSY, 16'h0, "wc_end");
        cyc();

        // ---------------- reset in the middle of a sweep ----------------
        bus_a.RegWrite = 1'b1; bus_a.write_register = 2'd3; bus_a.write_data = 8'h5A;
        cyc();
        bus_a.write_register = 2'd2; bus_a.write_data = 8'hC3;
        cyc();
        bus_a.RegWrite = 1'b0; bus_a.clear_req = 1'b1;
        cyc();
        bus_a.clear_req = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        bus_a.read_register_one = 2'd3; bus_a.read_register_two = 2'd2;
        expect_val(K_A_BUSY, 16'h0, "rst_mid_busy");
        expect_val(K_A_DROP, 16'h0, "rst_mid_drop");
        expect_val(K_A_RD1,  16'h0, "rst_mid_e3");
        expect_val(K_A_RD2,  16'h0, "rst_mid_e2");
        cyc();
        reset = 1'b0;
        cyc();
        bus_a.clear_req = 1'b1;
        expect_val(K_A_BUSY, 16'h0, "fresh_idle");
        cyc();
        bus_a.clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_val(K_A_BUSY, 16'h1, "fresh_sweep_busy");
            cyc();
        end
        expect_val(K_A_BUSY, 16'h0, "fresh_sweep_end");
        cyc();

        // ---------------- 16x8 instance with zero entry ----------------
        bus_b.RegWrite = 1'b1; bus_b.write_register = 3'd0; bus_b.write_data = 16'hBEEF;
        bus_b.read_register_one = 3'd0;
        expect_val(K_B_RD1, 16'h0000, "z_e0_same_cycle");
        cyc();
        bus_b.write_register = 3'd7; bus_b.write_data = 16'h1234;
        bus_b.read_register_one = 3'd7; bus_b.read_register_two = 3'd0;
        expect_val(K_B_RD1, c_byp ? 16'h1234 : 16'h0000, "z_e7_same_cycle");
        expect_val(K_B_RD2, 16'h0000, "z_e0_after_write");
        expect_val(K_B_DROP, 16'h0, "z_drop_zero_write");
        cyc();
        bus_b.RegWrite = 1'b0;
        expect_val(K_B_RD1, 16'h1234, "z_e7");
        expect_val(K_B_RD2, 16'h0000, "z_e0");
        expect_val(K_B_DROP, 16'h0, "z_drop");
        expect_val(K_B_BUSY, 16'h0, "z_busy");
        cyc();

        cyc(); cyc();
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_param

`default_nettype wire
